uart_rx_buffer_ctrl: RTL and testbench

Parametrised receive-side buffer controller between a UART RX module and an external dual-port synchronous RAM used as a circular FIFO. Captures each RX byte on the rising edge of the RX ready flag and writes it to RAM. Prefetches the oldest entry into an output holding register behind a valid/ready handshake. Overflow policy is selectable: overwrite oldest or drop newest. Separate RAM read and write buses; no bidirectional data.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rxbuf_rd_fetch.sv | 80 ++++++++
 rtl/uart_rx_buffer_ctrl.sv | 134 +++++++++++++
 tb/tb_uart_rx_buffer_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer controller:
// read-fetch FSM state encoding and default width/depth/latency constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        HOLD    = 2'd2
    } rd_state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_RD_LAT = 1;

endpackage

// File: rtl/uart_rxbuf_rd_fetch.sv
// Read-side fetch engine for the UART receive buffer.
// Issues one RAM read when data is buffered and the holding register is empty,
// waits RD_LAT cycles for the RAM, then presents the word behind valid/ready.
module uart_rxbuf_rd_fetch
    import uart_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              data_avail,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              out_ready,
    output logic              rd_issue,
    output logic              out_valid_nxt,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

    rd_state_e         state;
    rd_state_e         state_nxt;
    logic [1:0]        lat_cnt;
    logic [1:0]        lat_cnt_nxt;
    logic [DATA_W-1:0] data_nxt;

    // State, latency counter and holding register; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= 2'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_cnt_nxt;
            out_data  <= data_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // Next-state logic: fetch when idle, count RAM latency, hold until accepted.
    always_comb begin
        state_nxt     = state;
        lat_cnt_nxt   = lat_cnt;
        data_nxt      = out_data;
        out_valid_nxt = out_valid;
        rd_issue      = 1'b0;
        case (state)
            IDLE: begin
                if (data_avail) begin
                    rd_issue    = 1'b1;
                    lat_cnt_nxt = 2'd0;
                    state_nxt   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    data_nxt      = mem_rd_data;
                    out_valid_nxt = 1'b1;
                    state_nxt     = HOLD;
                end else begin
                    lat_cnt_nxt = lat_cnt + 2'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// Receive-side buffer controller: captures UART RX bytes into an external
// dual-port RAM used as a circular FIFO and prefetches the oldest word into a
// valid/ready holding register. OVERWRITE selects drop-oldest vs drop-newest.
// Optional macro RXBUF_WATERMARK_EN adds parameter AFULL_LVL and port almost_full.
module uart_rx_buffer_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RD_LAT    = DEF_RD_LAT,
    parameter bit OVERWRITE = 1'b1
`ifdef RXBUF_WATERMARK_EN
    ,
    parameter int AFULL_LVL = 3 * (2**ADDR_W) / 4
`endif
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              new_data,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
`ifdef RXBUF_WATERMARK_EN
    output logic              almost_full,
`endif
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef RXBUF_WATERMARK_EN
    localparam logic [ADDR_W:0]   AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);
`endif

    logic              rx_rdy_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              capture;
    logic              full;
    logic              rd_issue;
    logic              out_valid_nxt;
    logic              accept;
    logic              wr_go;
    logic              drop_oldest;
    logic              lost;
    logic              cnt_inc;
    logic [ADDR_W:0]   count_nxt;

    // A capture is a 0->1 transition of the RX ready level.
    assign capture = rx_rdy && !rx_rdy_q;
    assign full    = (count == DEPTH_CNT);
    assign accept  = out_valid && out_ready;

    // A simultaneous read issue frees a slot, so a full buffer only loses data without one.
    assign lost        = capture && full && !rd_issue;
    assign wr_go       = capture && (!full || rd_issue || OVERWRITE);
    assign drop_oldest = lost && OVERWRITE;
    assign cnt_inc     = capture && (!full || rd_issue);

    // Net occupancy change: one in per non-lost, non-overwriting capture, one out per issue.
    always_comb begin
        count_nxt = count + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, rd_issue};
    end

    // Pointers, occupancy, sticky overflow and the registered RAM strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_rdy_q    <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            new_data    <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
`ifdef RXBUF_WATERMARK_EN
            almost_full <= 1'b0;
`endif
        end else begin
            rx_rdy_q  <= rx_rdy;
            mem_wr_en <= wr_go;
            if (wr_go) begin
                mem_wr_addr <= wr_ptr;
                mem_wr_data <= rx_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            mem_rd_en <= rd_issue;
            if (rd_issue) begin
                mem_rd_addr <= rd_ptr;
            end
            if (rd_issue || drop_oldest) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_nxt;
            if (lost) begin
                overflow <= 1'b1;
            end else if (accept) begin
                overflow <= 1'b0;
            end
            new_data <= out_valid_nxt || (count_nxt != '0);
`ifdef RXBUF_WATERMARK_EN
            almost_full <= (count_nxt >= AFULL_CNT);
`endif
        end
    end

    uart_rxbuf_rd_fetch #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_fetch (
        .clk           (clk),
        .rst           (rst),
        .data_avail    (count != '0),
        .mem_rd_data   (mem_rd_data),
        .out_ready     (out_ready),
        .rd_issue      (rd_issue),
        .out_valid_nxt (out_valid_nxt),
        .out_data      (out_data),
        .out_valid     (out_valid)
    );

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Bench for uart_rx_buffer_ctrl: two 4-entry instances share the stimulus,
// one overwriting the oldest word (RD_LAT=1), one dropping the newest (RD_LAT=2).
// Expected words are queued per instance and popped by a monitor on each handshake.
// Honours RXBUF_WATERMARK_EN for the almost_full port.
module tb_uart_rx_buffer_ctrl;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_rdy;
    logic          out_ready;

    logic [7:0]    out_data_a,    out_data_b;
    logic          out_valid_a,   out_valid_b;
    logic          new_data_a,    new_data_b;
    logic [AW:0]   count_a,       count_b;
    logic          overflow_a,    overflow_b;
    logic          mem_wr_en_a,   mem_wr_en_b;
    logic [AW-1:0] mem_wr_addr_a, mem_wr_addr_b;
    logic [7:0]    mem_wr_data_a, mem_wr_data_b;
    logic          mem_rd_en_a,   mem_rd_en_b;
    logic [AW-1:0] mem_rd_addr_a, mem_rd_addr_b;
    logic [7:0]    mem_rd_data_a, mem_rd_data_b;
`ifdef RXBUF_WATERMARK_EN
    logic          almost_full_a, almost_full_b;
`endif

    logic [7:0]    ram_a [4];
    logic [7:0]    ram_b [4];
    logic [7:0]    pipe_b;

    logic [7:0]    exp_a [$];
    logic [7:0]    exp_b [$];

    int            checks = 0;
    int            errors = 0;
    int            wr_cnt_a = 0, wr_cnt_b = 0;
    int            ovf_cyc_a = 0, ovf_cyc_b = 0;

    always #5 clk = ~clk;

    uart_rx_buffer_ctrl #(
        .DATA_W (8), .ADDR_W (AW), .RD_LAT (1), .OVERWRITE (1'b1)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .out_data    (out_data_a),
        .out_valid   (out_valid_a),
        .out_ready   (out_ready),
        .new_data    (new_data_a),
        .count       (count_a),
        .overflow    (overflow_a),
`ifdef RXBUF_WATERMARK_EN
        .almost_full (almost_full_a),
`endif
        .mem_wr_en   (mem_wr_en_a),
        .mem_wr_addr (mem_wr_addr_a),
        .mem_wr_data (mem_wr_data_a),
        .mem_rd_en   (mem_rd_en_a),
        .mem_rd_addr (mem_rd_addr_a),
        .mem_rd_data (mem_rd_data_a)
    );

    uart_rx_buffer_ctrl #(
        .DATA_W (8), .ADDR_W (AW), .RD_LAT (2), .OVERWRITE (1'b0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .out_data    (out_data_b),
        .out_valid   (out_valid_b),
        .out_ready   (out_ready),
        .new_data    (new_data_b),
        .count       (count_b),
        .overflow    (overflow_b),
`ifdef RXBUF_WATERMARK_EN
        .almost_full (almost_full_b),
`endif
        .mem_wr_en   (mem_wr_en_b),
        .mem_wr_addr (mem_wr_addr_b),
        .mem_wr_data (mem_wr_data_b),
        .mem_rd_en   (mem_rd_en_b),
        .mem_rd_addr (mem_rd_addr_b),
        .mem_rd_data (mem_rd_data_b)
    );

    // Read-first RAM, one cycle of read latency.
    always @(posedge clk) begin
        if (mem_rd_en_a) mem_rd_data_a <= ram_a[mem_rd_addr_a];
        if (mem_wr_en_a) ram_a[mem_wr_addr_a] <= mem_wr_data_a;
    end

    // Read-first RAM, two cycles of read latency.
    always @(posedge clk) begin
        if (mem_rd_en_b) pipe_b <= ram_b[mem_rd_addr_b];
        mem_rd_data_b <= pipe_b;
        if (mem_wr_en_b) ram_b[mem_wr_addr_b] <= mem_wr_data_b;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor for instance a: every handshake must match the oldest queued word.
    always @(negedge clk) begin
        if (mem_wr_en_a) wr_cnt_a++;
        if (overflow_a) ovf_cyc_a++;
        if (!rst && out_valid_a && out_ready) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL mon_a extra word: got %02h, expected none", out_data_a);
            end else begin
                checkOutput("mon_a out_data", {24'd0, out_data_a}, {24'd0, exp_a.pop_front()});
            end
        end
    end

    // Monitor for instance b: every handshake must match the oldest queued word.
    always @(negedge clk) begin
        if (mem_wr_en_b) wr_cnt_b++;
        if (overflow_b) ovf_cyc_b++;
        if (!rst && out_valid_b && out_ready) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL mon_b extra word: got %02h, expected none", out_data_b);
            end else begin
                checkOutput("mon_b out_data", {24'd0, out_data_b}, {24'd0, exp_b.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One rising edge of rx_rdy carrying b; the word is queued for each instance expected to deliver it.
    task automatic applyStimulus(input logic [7:0] b, input int hi, input int lo, input bit push_a, input bit push_b);
        if (push_a) exp_a.push_back(b);
        if (push_b) exp_b.push_back(b);
        rx_data = b;
        rx_rdy  = 1'b1;
        tick(hi);
        rx_rdy  = 1'b0;
        tick(lo);
    endtask

    task automatic drain_wait(input int budget);
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput("drain queue a", exp_a.size(), 0);
        checkOutput("drain queue b", exp_b.size(), 0);
        exp_a.delete();
        exp_b.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w_a, w_b, o_a, o_b;
        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; out_ready = 1'b0;
        tick(3);
        checkOutput("rst out_valid_a", out_valid_a, 0);
        checkOutput("rst out_valid_b", out_valid_b, 0);
        checkOutput("rst count_a", count_a, 0);
        checkOutput("rst overflow_a", overflow_a, 0);
        checkOutput("rst new_data_a", new_data_a, 0);
        checkOutput("rst mem_wr_en_a", mem_wr_en_a, 0);
        checkOutput("rst mem_rd_en_b", mem_rd_en_b, 0);
        checkOutput("rst out_data_b", out_data_b, 0);
`ifdef RXBUF_WATERMARK_EN
        checkOutput("rst almost_full_a", almost_full_a, 0);
`endif
        rst = 1'b0;
        tick(1);

        // Single byte: write pulse, fetch and latency to out_valid.
        applyStimulus(8'hA5, 1, 0, 1'b1, 1'b1);
        checkOutput("t1 mem_wr_en_a", mem_wr_en_a, 1);
        checkOutput("t1 mem_wr_addr_a", mem_wr_addr_a, 0);
        checkOutput("t1 mem_wr_data_a", mem_wr_data_a, 8'hA5);
        checkOutput("t1 mem_wr_data_b", mem_wr_data_b, 8'hA5);
        checkOutput("t1 count_a", count_a, 1);
        checkOutput("t1 new_data_a", new_data_a, 1);
        tick(1);
        checkOutput("t1 mem_wr_en_a pulse", mem_wr_en_a, 0);
        checkOutput("t1 mem_rd_en_a", mem_rd_en_a, 1);
        checkOutput("t1 mem_rd_addr_a", mem_rd_addr_a, 0);
        checkOutput("t1 count_a after issue", count_a, 0);
        tick(1);
        checkOutput("t1 out_valid_a early", out_valid_a, 0);
        tick(1);
        checkOutput("t1 out_valid_a", out_valid_a, 1);
        checkOutput("t1 out_data_a", out_data_a, 8'hA5);
        checkOutput("t1 new_data_a held", new_data_a, 1);
        checkOutput("t1 out_valid_b early", out_valid_b, 0);
        tick(1);
        checkOutput("t1 out_valid_b", out_valid_b, 1);
        checkOutput("t1 out_data_b", out_data_b, 8'hA5);
        out_ready = 1'b1;
        tick(1);
        checkOutput("t1 out_valid_a after accept", out_valid_a, 0);
        checkOutput("t1 new_data_a after accept", new_data_a, 0);
        checkOutput("t1 new_data_b after accept", new_data_b, 0);
        checkOutput("t1 count_b after accept", count_b, 0);
        drain_wait(20);

        // rx_rdy held high for many cycles is a single capture.
        w_a = wr_cnt_a; w_b = wr_cnt_b;
        applyStimulus(8'h3C, 10, 4, 1'b1, 1'b1);
        checkOutput("held rdy writes a", wr_cnt_a - w_a, 1);
        checkOutput("held rdy writes b", wr_cnt_b - w_b, 1);
        drain_wait(20);

        // rx_rdy high across reset release is not captured until it toggles.
        w_a = wr_cnt_a; w_b = wr_cnt_b;
        rx_data = 8'h77; rx_rdy = 1'b1; rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        checkOutput("rdy thru rst writes a", wr_cnt_a - w_a, 0);
        checkOutput("rdy thru rst writes b", wr_cnt_b - w_b, 0);
        rx_rdy = 1'b0;
        tick(1);
        applyStimulus(8'h77, 1, 4, 1'b1, 1'b1);
        checkOutput("rdy retoggle writes a", wr_cnt_a - w_a, 1);
        checkOutput("rdy retoggle addr a", mem_wr_addr_a, 0);
        drain_wait(20);

        // Overflow: six bytes into a four-entry RAM plus holding register.
        out_ready = 1'b0;
        tick(2);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = 8'h10 + 8'(i);
            applyStimulus(b, 1, 1, (b != 8'h11), (b != 8'h15));
        end
        tick(4);
        checkOutput("ovf overflow_a", overflow_a, 1);
        checkOutput("ovf overflow_b", overflow_b, 1);
        checkOutput("ovf count_a", count_a, 4);
        checkOutput("ovf count_b", count_b, 4);
        checkOutput("ovf out_data_a", out_data_a, 8'h10);
        checkOutput("ovf out_data_b", out_data_b, 8'h10);
`ifdef RXBUF_WATERMARK_EN
        checkOutput("ovf almost_full_a", almost_full_a, 1);
        checkOutput("ovf almost_full_b", almost_full_b, 1);
`endif
        out_ready = 1'b1;
        tick(1);
        checkOutput("ovf clear overflow_a", overflow_a, 0);
        checkOutput("ovf clear overflow_b", overflow_b, 0);
        drain_wait(60);
        tick(3);
        checkOutput("ovf drained count_a", count_a, 0);
`ifdef RXBUF_WATERMARK_EN
        checkOutput("ovf drained almost_full_a", almost_full_a, 0);
`endif

        // Long stream: pointers wrap many times with no loss.
        o_a = ovf_cyc_a; o_b = ovf_cyc_b;
        for (int i = 0; i < 600; i++) begin
            applyStimulus(8'(i), 1, 7, 1'b1, 1'b1);
        end
        drain_wait(40);
        checkOutput("stream overflow cycles a", ovf_cyc_a - o_a, 0);
        checkOutput("stream overflow cycles b", ovf_cyc_b - o_b, 0);
        checkOutput("stream count_b", count_b, 0);

        // Reset while a read is in flight with two words still buffered.
        out_ready = 1'b0;
        applyStimulus(8'h81, 1, 1, 1'b1, 1'b1);
        applyStimulus(8'h82, 1, 1, 1'b0, 1'b0);
        applyStimulus(8'h83, 1, 1, 1'b0, 1'b0);
        applyStimulus(8'h84, 1, 1, 1'b0, 1'b0);
        tick(4);
        checkOutput("mid count_a", count_a, 3);
        checkOutput("mid count_b", count_b, 3);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(1);
        checkOutput("mid rd_wait count_a", count_a, 2);
        checkOutput("mid rd_wait count_b", count_b, 2);
        checkOutput("mid rd_wait mem_rd_en_a", mem_rd_en_a, 1);
        rst = 1'b1;
        tick(1);
        checkOutput("mid rst out_valid_a", out_valid_a, 0);
        checkOutput("mid rst out_valid_b", out_valid_b, 0);
        checkOutput("mid rst count_a", count_a, 0);
        checkOutput("mid rst count_b", count_b, 0);
        checkOutput("mid rst overflow_a", overflow_a, 0);
        rst = 1'b0;
        tick(1);
        applyStimulus(8'h5C, 1, 0, 1'b1, 1'b1);
        checkOutput("post rst mem_wr_addr_a", mem_wr_addr_a, 0);
        checkOutput("post rst mem_wr_addr_b", mem_wr_addr_b, 0);
        checkOutput("post rst mem_wr_en_b", mem_wr_en_b, 1);
        out_ready = 1'b1;
        drain_wait(20);
        tick(4);
        checkOutput("final out_valid_b", out_valid_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
